// File: rtl/tsn_rx_pkg.sv
// Shared definitions for the host receive path: sizing, write-stage states and
// the descriptor field layout that the queueing stage also decodes.
package tsn_rx_pkg;

  localparam int unsigned BUFID_W        = 9;
  localparam int unsigned WIDX_W         = 7;
  localparam int unsigned LEN_W          = 12;
  localparam int unsigned BYTES_PER_WORD = 16;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  localparam int unsigned DESC_LEN_LSB   = 0;
  localparam int unsigned DESC_BUFID_LSB = LEN_W;
  localparam int unsigned DESC_TRUNC_BIT = LEN_W + BUFID_W;
  localparam int unsigned DESC_W         = 1 + BUFID_W + LEN_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_TRUNC = 2'd2
  } wr_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes MSB-lane-first into a 128-bit word and requests a flush
// on lane 15 or on the last byte; the flushed word is presented combinationally.
module byte_word_packer
  import tsn_rx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_accept,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [7:0]        iv_byte,
  output logic              o_flush,
  output logic [WORD_W-1:0] ov_word
);

  logic [WORD_W-1:0] lanes;
  logic [LANE_W-1:0] lane_cnt;
  logic [LANE_W-1:0] lane;

  // A first byte always starts from a clean word in lane 0.
  always_comb begin
    lane    = i_first ? '0 : lane_cnt;
    ov_word = i_first ? '0 : lanes;
    for (int unsigned l = 0; l < BYTES_PER_WORD; l++) begin
      if (LANE_W'(l) == lane) ov_word[8*(BYTES_PER_WORD-1-l) +: 8] = iv_byte;
    end
    o_flush = i_accept && ((lane == LANE_W'(BYTES_PER_WORD-1)) || i_last);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lanes    <= '0;
      lane_cnt <= '0;
    end else if (i_accept) begin
      if (o_flush) begin
        lanes    <= '0;
        lane_cnt <= '0;
      end else begin
        lanes    <= ov_word;
        lane_cnt <= lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_buffer_write.sv
// Packet-buffer write stage: packs the tagged byte stream into 128-bit words,
// writes them at {bufid, word_idx} and emits one descriptor per packet.
module pkt_buffer_write
  import tsn_rx_pkg::*;
#(
  parameter int unsigned BUFID_W = tsn_rx_pkg::BUFID_W,
  parameter int unsigned WIDX_W  = tsn_rx_pkg::WIDX_W,
  parameter int unsigned LEN_W   = tsn_rx_pkg::LEN_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [8:0]                iv_data,
  input  logic                      i_data_wr,
  input  logic [BUFID_W-1:0]        iv_bufid,
  output logic [127:0]              ov_pkt_wdata,
  output logic [BUFID_W+WIDX_W-1:0] ov_pkt_waddr,
  output logic                      o_pkt_wr,
  output logic [BUFID_W+LEN_W:0]    ov_desc,
  output logic                      o_desc_wr
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'((2**WIDX_W) * BYTES_PER_WORD);

  wr_state_t          state, state_nxt;
  logic [BUFID_W-1:0] bufid_q, bufid_cur;
  logic [LEN_W-1:0]   byte_cnt, cnt_nxt, desc_len;
  logic [WIDX_W-1:0]  word_idx, widx_cur;
  logic               accept, first, last, desc_fire, desc_trunc, flush;
  logic [127:0]       flush_word;

  assign last = iv_data[8];

  byte_word_packer u_packer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_accept (accept),
    .i_first  (first),
    .i_last   (last),
    .iv_byte  (iv_data[7:0]),
    .o_flush  (flush),
    .ov_word  (flush_word)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    first      = 1'b0;
    desc_fire  = 1'b0;
    desc_trunc = 1'b0;
    cnt_nxt    = byte_cnt;
    desc_len   = byte_cnt;
    unique case (state)
      ST_IDLE: begin
        if (i_data_wr) begin
          accept  = 1'b1;
          first   = 1'b1;
          cnt_nxt = LEN_W'(1);
          if (last) begin
            desc_fire = 1'b1;
            desc_len  = cnt_nxt;
          end else begin
            state_nxt = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (i_data_wr) begin
          accept  = 1'b1;
          cnt_nxt = byte_cnt + 1'b1;
          if (last) begin
            desc_fire = 1'b1;
            desc_len  = cnt_nxt;
            state_nxt = ST_IDLE;
          end else if (cnt_nxt == MAX_LEN) begin
            state_nxt = ST_TRUNC;
          end
        end
      end
      ST_TRUNC: begin
        if (i_data_wr && last) begin
          desc_fire  = 1'b1;
          desc_trunc = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    bufid_cur = first ? iv_bufid : bufid_q;
    widx_cur  = first ? '0 : word_idx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      bufid_q      <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      ov_pkt_wdata <= '0;
      ov_pkt_waddr <= '0;
      o_pkt_wr     <= 1'b0;
      ov_desc      <= '0;
      o_desc_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (first) bufid_q <= iv_bufid;
      if (accept) word_idx <= flush ? widx_cur + 1'b1 : widx_cur;
      byte_cnt <= cnt_nxt;
      if (desc_fire) begin
        byte_cnt <= '0;
        word_idx <= '0;
      end
      o_pkt_wr <= flush;
      if (flush) begin
        ov_pkt_wdata <= flush_word;
        ov_pkt_waddr <= {bufid_cur, widx_cur};
      end
      o_desc_wr <= desc_fire;
      if (desc_fire) ov_desc <= {desc_trunc, bufid_cur, desc_len};
    end
  end

endmodule

// File: tb/tb_pkt_buffer_write.sv
// Directed bench for pkt_buffer_write: hand-computed words, addresses and descriptors.
module tb_pkt_buffer_write;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [8:0]   iv_data;
  logic         i_data_wr;
  logic [8:0]   iv_bufid;
  logic [127:0] ov_pkt_wdata;
  logic [15:0]  ov_pkt_waddr;
  logic         o_pkt_wr;
  logic [21:0]  ov_desc;
  logic         o_desc_wr;

  pkt_buffer_write #(.BUFID_W(9), .WIDX_W(7), .LEN_W(12)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .iv_data      (iv_data),
    .i_data_wr    (i_data_wr),
    .iv_bufid     (iv_bufid),
    .ov_pkt_wdata (ov_pkt_wdata),
    .ov_pkt_waddr (ov_pkt_waddr),
    .o_pkt_wr     (o_pkt_wr),
    .ov_desc      (ov_desc),
    .o_desc_wr    (o_desc_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]  wa_q[$];
  logic [127:0] wd_q[$];
  int           wc_q[$];
  logic [21:0]  d_q[$];
  int           dc_q[$];

  always @(negedge clk) begin
    if (o_pkt_wr) begin
      wa_q.push_back(ov_pkt_waddr);
      wd_q.push_back(ov_pkt_wdata);
      wc_q.push_back(cyc);
    end
    if (o_desc_wr) begin
      d_q.push_back(ov_desc);
      dc_q.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] wd_at(input int i);
    if (i < wd_q.size()) return wd_q[i];
    return '1;
  endfunction
  function automatic logic [15:0] wa_at(input int i);
    if (i < wa_q.size()) return wa_q[i];
    return '1;
  endfunction
  function automatic int wc_at(input int i);
    if (i < wc_q.size()) return wc_q[i];
    return -1;
  endfunction
  function automatic logic [21:0] d_at(input int i);
    if (i < d_q.size()) return d_q[i];
    return '1;
  endfunction
  function automatic int dc_at(input int i);
    if (i < dc_q.size()) return dc_q[i];
    return -1;
  endfunction

  // n bytes starting at value base, left-aligned, zero-filled.
  function automatic logic [127:0] word_of(input int base, input int n);
    logic [127:0] w = '0;
    for (int k = 0; k < 16; k++) w = {w[119:0], (k < n) ? 8'(base + k) : 8'h00};
    return w;
  endfunction

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); d_q.delete(); dc_q.delete();
  endtask

  int last_edge;
  task automatic send(input logic [7:0] b, input logic lst, input logic [8:0] bid);
    @(negedge clk);
    iv_data   = {lst, b};
    iv_bufid  = bid;
    i_data_wr = 1'b1;
    last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_data_wr = 1'b0;
      iv_data   = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int e0, e1;
    rst_n = 1'b0; i_data_wr = 1'b0; iv_data = '0; iv_bufid = '0;
    repeat (3) @(negedge clk);
    check("rst_wdata", ov_pkt_wdata, 128'd0);
    check("rst_waddr", ov_pkt_waddr, 128'd0);
    check("rst_pkt_wr", o_pkt_wr, 128'd0);
    check("rst_desc", ov_desc, 128'd0);
    check("rst_desc_wr", o_desc_wr, 128'd0);
    rst_n = 1'b1;
    idle(2);

    // 1-byte packet
    clear_q();
    send(8'hAB, 1'b1, 9'h005);
    e0 = last_edge;
    idle(3);
    check("t1_nwr", wa_q.size(), 128'd1);
    check("t1_addr", wa_at(0), {9'h005, 7'd0});
    check("t1_data", wd_at(0), {8'hAB, 120'd0});
    check("t1_desc", d_at(0), {1'b0, 9'h005, 12'd1});
    check("t1_wr_lat", wc_at(0), e0);
    check("t1_desc_lat", dc_at(0), e0);

    // 64-byte back-to-back packet
    clear_q();
    for (int i = 0; i < 64; i++) send(8'(i), i == 63, 9'h1FF);
    idle(3);
    check("t2_nwr", wa_q.size(), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), wa_at(i), {9'h1FF, 7'(i)});
      check($sformatf("t2_data%0d", i), wd_at(i), word_of(16 * i, 16));
    end
    check("t2_desc", d_at(0), {1'b0, 9'h1FF, 12'd64});

    // 17 bytes with gaps, then a 1-byte packet with no bubble
    clear_q();
    for (int i = 0; i < 17; i++) begin
      send(8'(8'hA0 + i), i == 16, 9'h033);
      if (i == 3 || i == 8 || i == 12) idle(2);
    end
    e0 = last_edge;
    send(8'h55, 1'b1, 9'h044);
    e1 = last_edge;
    idle(3);
    check("t3_nwr", wa_q.size(), 128'd3);
    check("t3_addr0", wa_at(0), {9'h033, 7'd0});
    check("t3_data0", wd_at(0), word_of(8'hA0, 16));
    check("t3_addr1", wa_at(1), {9'h033, 7'd1});
    check("t3_data1", wd_at(1), {8'hB0, 120'd0});
    check("t3_addr2", wa_at(2), {9'h044, 7'd0});
    check("t3_data2", wd_at(2), {8'h55, 120'd0});
    check("t3_desc0", d_at(0), {1'b0, 9'h033, 12'd17});
    check("t3_desc1", d_at(1), {1'b0, 9'h044, 12'd1});
    check("t3_desc0_lat", dc_at(0), e0);
    check("t3_desc1_lat", dc_at(1), e1);

    // 2100-byte packet truncated at 2048
    clear_q();
    for (int i = 0; i < 2100; i++) begin
      send(8'(i), i == 2099, 9'h0AA);
      if (i == 2047) e0 = last_edge;
    end
    e1 = last_edge;
    idle(3);
    check("t4_nwr", wa_q.size(), 128'd128);
    check("t4_addr0", wa_at(0), {9'h0AA, 7'd0});
    check("t4_addr127", wa_at(127), {9'h0AA, 7'd127});
    check("t4_data127", wd_at(127), word_of(2032, 16));
    check("t4_wr127_lat", wc_at(127), e0);
    check("t4_ndesc", d_q.size(), 128'd1);
    check("t4_desc", d_at(0), {1'b1, 9'h0AA, 12'd2048});
    check("t4_desc_lat", dc_at(0), e1);

    // reset mid-packet, then a 20-byte packet
    clear_q();
    for (int i = 0; i < 10; i++) send(8'(8'hE0 + i), 1'b0, 9'h077);
    @(negedge clk);
    i_data_wr = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i), i == 19, 9'h011);
    idle(3);
    check("t5_nwr", wa_q.size(), 128'd2);
    check("t5_addr0", wa_at(0), {9'h011, 7'd0});
    check("t5_data0", wd_at(0), word_of(8'h40, 16));
    check("t5_addr1", wa_at(1), {9'h011, 7'd1});
    check("t5_data1", wd_at(1), word_of(8'h50, 4));
    check("t5_ndesc", d_q.size(), 128'd1);
    check("t5_desc", d_at(0), {1'b0, 9'h011, 12'd20});

    // bufid toggling mid-packet is ignored
    clear_q();
    for (int i = 0; i < 20; i++)
      send(8'(8'h10 + i), i == 19, (i == 0) ? 9'h123 : ((i % 2) ? 9'h0DC : 9'h1A5));
    idle(3);
    check("t6_nwr", wa_q.size(), 128'd2);
    check("t6_addr0", wa_at(0), {9'h123, 7'd0});
    check("t6_addr1", wa_at(1), {9'h123, 7'd1});
    check("t6_data1", wd_at(1), word_of(8'h20, 4));
    check("t6_desc", d_at(0), {1'b0, 9'h123, 12'd20});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_buffer_write.md
# pkt_buffer_write

Packet-buffer write stage fed directly by `buffer_address_receive` in the host receive path. It accepts the 9-bit byte stream and the buffer ID that stream is tagged with, and packs bytes into 128-bit words. Each word is written into the shared packet buffer at `{bufid, word index}`. At end of packet it emits one descriptor carrying the buffer ID, the byte length and a truncation flag to the downstream queueing logic.

## Interface
Parameters:
- `BUFID_W`, 9: buffer ID width.
- `WIDX_W`, 7: word-index width. Maximum packet size is 2^WIDX_W words of 16 B, i.e. 2048 B.
- `LEN_W`, 12: byte-length field width. Must hold 2048.

Ports:
- `i_clk` in 1: the block's only clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `iv_data` in 9: bit 8 = last byte of packet; bits 7:0 = byte.
- `i_data_wr` in 1: `iv_data` valid. Gaps are allowed mid-packet.
- `iv_bufid` in BUFID_W: buffer ID. Sampled only on a packet's first valid byte.
- `ov_pkt_wdata` out 128: packed word. The first byte of the word is in [127:120].
- `ov_pkt_waddr` out BUFID_W+WIDX_W: `{bufid, word_idx}`.
- `o_pkt_wr` out 1: one-cycle write strobe.
- `ov_desc` out 1+BUFID_W+LEN_W: `{trunc_err, bufid, byte_len}`.
- `o_desc_wr` out 1: one-cycle descriptor strobe.

## Operation
- States:
  - IDLE: waiting for a packet.
  - RECV: packing a packet.
  - TRUNC: dropping bytes past the maximum size.
- IDLE:
  - On `i_data_wr`: latch `iv_bufid`, set byte_cnt=1, place the byte in lane 0, set word_idx=0.
  - If bit 8 is also set, finish immediately as a 1-byte packet and stay in IDLE. Otherwise go to RECV.
- RECV: each valid byte goes to lane byte_cnt[3:0], then byte_cnt increments.
  - When lane 15 is filled, or on the last byte, flush. A flush registers the word to `ov_pkt_wdata`/`ov_pkt_waddr`, pulses `o_pkt_wr`, increments word_idx, and clears the packing register.
  - Unfilled lanes of a partial final word are 0.
- End of packet: `o_desc_wr` pulses in the same cycle as the final `o_pkt_wr`. `ov_desc` = {trunc_err, latched bufid, byte_cnt}. Return to IDLE.
- Overflow: the 2048th byte fills word 127 and is flushed normally. If it is not the last byte, go to TRUNC and set trunc_err.
- TRUNC: discard all bytes without counting them. On a valid byte with bit 8 set, emit the descriptor with byte_len=2048 and trunc_err=1, with no extra word write. Return to IDLE.
- Flush and next capture are independent:
  - The output registers are separate from the packing register.
  - A last byte in cycle N followed by a new packet's first byte in cycle N+1 is accepted with no bubble.
  - The new `iv_bufid` is latched in cycle N+1.
- `iv_bufid` is ignored on every byte that is not a first byte.
- Width rules:
  - byte_cnt is LEN_W bits and never exceeds 2048.
  - word_idx wraps only when it returns to IDLE (cleared); it never wraps within a packet.

## Timing
- Reset values: every output 0, state IDLE, counters and packing register 0.
- Reset asserted mid-packet: the partial word and descriptor are discarded. Nothing is emitted in the cycle after release.
- Latency: a byte accepted in cycle N that completes a word or ends the packet gives `o_pkt_wr` high in cycle N+1. `o_desc_wr`, when due, is also high in cycle N+1.
- Strobes are single-cycle. Data and address outputs hold their value until the next strobe.
- Sustained throughput is 1 byte per clock. There is no backpressure; the buffer write port must accept a write on any cycle.

## Structure
- Shared package `tsn_rx_pkg`: BUFID_W, WIDX_W, LEN_W, BYTES_PER_WORD=16, the state encoding, and the descriptor field offsets. The descriptor offsets are shared with the queueing stage.
- One natural sub-module, `byte_word_packer`. It owns the lane register, lane counter and flush request. The FSM, counters and descriptor generation stay in the top level.

## Test plan
- 1-byte packet, byte 0xAB with bit 8 set, bufid 0x05 → one write: addr {0x05,0}, wdata 0xAB followed by 120 zero bits; desc {0,0x05,1}. Both strobes are in the cycle after the byte.
- 64-byte packet, bytes 0x00..0x3F back-to-back, bufid 0x1FF → 4 writes at word_idx 0..3; word 0 = 0x000102…0F; desc length 64.
- 17-byte packet with random `i_data_wr` gaps, followed by a 1-byte packet in the very next cycle (different bufid) → the first packet writes words 0 and 1 (word 1 holds one byte), desc length 17; the second packet's desc carries the new bufid with no bubble.
- 2100-byte packet → 128 writes, no write for bytes 2049–2100, desc {1, bufid, 2048}.
- Reset pulsed after 10 bytes of a packet, then a 20-byte packet → no write or desc from the aborted packet; the 20-byte packet writes word_idx 0 and 1, desc length 20.
- `iv_bufid` toggled on every cycle mid-packet → all writes and the desc use the bufid sampled on the first byte.
